// File: rtl/alu_pkg.sv
// Op codes, decode helpers and FSM state for the RV32IM execute unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  function automatic logic is_base(input logic [4:0] op);
    return op <= OP_AND;
  endfunction

  // M ops occupy 16..23: bit4 set, bit3 clear
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return is_base(op) || is_muldiv(op);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return is_muldiv(op) && op[2];
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return is_div(op) && op[1];
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared one-bit-per-cycle multiply/divide datapath: XLEN iterations on
// unsigned magnitudes, then one cycle where the signed result is presented.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [SHW:0] ITERS = (SHW+1)'(XLEN);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd_b;
  logic [4:0]        op_q;
  logic              neg_res, neg_rem;
  logic [SHW:0]      cnt;
  logic              busy;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  assign a_neg = is_signed_a(op_i) & a_i[XLEN-1];
  assign b_neg = is_signed_b(op_i) & b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // acc = {hi, lo}: multiply keeps the multiplier in lo and shifts right,
  // divide keeps the dividend in lo and shifts the partial remainder left.
  logic [XLEN:0]     add_sum, rem_sh, diff;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_b} : '0);
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opnd_b};
    if (is_div(op_q)) begin
      acc_nxt = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                           : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {add_sum, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (is_div(op_q))        result_o = is_rem(op_q) ? rem : quo;
    else if (op_q == OP_MUL) result_o = prod[XLEN-1:0];
    else                     result_o = prod[2*XLEN-1:XLEN];
  end

  assign done_o = busy && (cnt == ITERS);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc     <= '0;
      opnd_b  <= '0;
      op_q    <= OP_MUL;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (flush_i) begin
      busy <= 1'b0;
    end else if (start_i) begin
      acc     <= {{XLEN{1'b0}}, a_mag};
      opnd_b  <= b_mag;
      op_q    <= op_i;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      cnt     <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (cnt == ITERS) begin
        busy <= 1'b0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// RV32IM execute unit: single-cycle base ALU ops and special divides,
// iterative multiply/divide, valid/ready on both sides.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e state;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res, spec_res, fast_res, md_res;
  logic            div_zero, div_ovf, special, iter_op, iter_start, md_done;

  assign ready_o = (state == ST_IDLE);
  assign shamt   = operand_b_i[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (op_i)
      OP_ADD:  base_res = operand_a_i + operand_b_i;
      OP_SUB:  base_res = operand_a_i - operand_b_i;
      OP_SLL:  base_res = operand_a_i << shamt;
      OP_SLT:  base_res[0] = $signed(operand_a_i) < $signed(operand_b_i);
      OP_SLTU: base_res[0] = operand_a_i < operand_b_i;
      OP_XOR:  base_res = operand_a_i ^ operand_b_i;
      OP_SRL:  base_res = operand_a_i >> shamt;
      OP_SRA:  base_res = $unsigned($signed(operand_a_i) >>> shamt);
      OP_OR:   base_res = operand_a_i | operand_b_i;
      OP_AND:  base_res = operand_a_i & operand_b_i;
      default: base_res = '0;
    endcase
  end

  // Divides whose result is fixed by the operands skip the iterative path
  assign div_zero = (operand_b_i == '0);
  assign div_ovf  = is_signed_a(op_i) && (operand_a_i == INT_MIN) && (operand_b_i == '1);
  assign special  = is_div(op_i) && (div_zero || div_ovf);

  always_comb begin
    if (div_zero) spec_res = is_rem(op_i) ? operand_a_i : '1;
    else          spec_res = is_rem(op_i) ? '0 : operand_a_i;
    if (!is_legal(op_i))      fast_res = '0;
    else if (is_muldiv(op_i)) fast_res = spec_res;
    else                      fast_res = base_res;
  end

  assign iter_op    = is_muldiv(op_i) && !special;
  assign iter_start = ready_o && valid_i && !flush_i && iter_op;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv_iter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .start_i  (iter_start),
    .op_i     (op_i),
    .a_i      (operand_a_i),
    .b_i      (operand_b_i),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      valid_o   <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      state   <= ST_IDLE;
      valid_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            if (iter_op) begin
              state <= ST_BUSY;
            end else begin
              result_o  <= fast_res;
              zero_o    <= (fast_res == '0);
              illegal_o <= !is_legal(op_i);
              valid_o   <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            result_o  <= md_res;
            zero_o    <= (md_res == '0);
            illegal_o <= 1'b0;
            valid_o   <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, handshaked execute unit for the RV32IM core: performs every RV32I ALU operation plus the eight RV32M multiply/divide operations behind a valid/ready interface. Base ops retire in one registered cycle; multiply and divide run iteratively (one bit per cycle) in a shared datapath. The unit sits in the EX stage in place of the combinational ALU plus separate multiplier, and stalls the pipeline through `ready_o`/`valid_o`.

## Interface
- `XLEN`, default 32: operand/result width; power of two, ≥ 8.
- `SHW`, default $clog2(XLEN): shift-amount width, derived, not overridden.
- `clk_i` input 1: clock, rising edge.
- `rst_ni` input 1: reset; one clock, reset is asynchronous and active-low.
- `flush_i` input 1: synchronous abort of any in-flight operation.
- `valid_i` input 1: operands and op valid.
- `ready_o` output 1: unit can accept; high only in IDLE.
- `op_i` input 5: operation code (`alu_pkg`).
- `operand_a_i` input XLEN: rs1 / PC / zero.
- `operand_b_i` input XLEN: rs2 / immediate.
- `valid_o` output 1: result valid; held until accepted.
- `ready_i` input 1: consumer accepts the result.
- `result_o` output XLEN: registered result.
- `zero_o` output 1: `result_o == 0`, registered with `result_o`.
- `illegal_o` output 1: op code undefined; `result_o` = 0.

## Operation
- Op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9; MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23. Every other code is illegal.
- Shifts use `operand_b_i[SHW-1:0]`. SLT is signed; SLTU is unsigned. Results are zero-extended 0/1.
- States:
  - IDLE: on `valid_i` with a base op, an illegal op, or a special divide → DONE. On any other M op → BUSY.
  - BUSY: counts `XLEN` iterations plus one sign-fix cycle, then → DONE.
  - DONE: `valid_o`=1. On `ready_i` → IDLE.
- Multiply: operand magnitudes are taken per signedness (MULH s×s, MULHSU s×u, MULHU u×u). The unit forms the 2·XLEN-bit unsigned shift-add product, then negates it in the fix cycle if the signs differ. MUL returns the low half; the others return the high half.
- Divide: restoring, unsigned magnitudes. The quotient sign is a XOR b; the remainder sign follows the dividend.
- Special divides resolve in 1 cycle with no BUSY:
  - Divisor 0: DIV/DIVU → all-ones; REM/REMU → a.
  - Signed overflow (a = −2^(XLEN−1), b = −1): DIV → a; REM → 0.
- Operands and op are latched at acceptance. Later input changes have no effect.

## Timing
- Reset values: `valid_o` 0, `result_o` 0, `zero_o` 0, `illegal_o` 0, state IDLE. `ready_o` is combinational from state, so it is 1 during and after reset.
- Acceptance happens at edge t when `valid_i && ready_o`.
  - Base, illegal and special-divide ops: `valid_o` at t+1.
  - Iterative M ops: `valid_o` at t+XLEN+2 (34 for XLEN=32).
- Output handshake completes at the edge where `valid_o && ready_i`. `ready_o` rises the following cycle; there is no same-cycle re-accept (max throughput: 1 op per 2 cycles).
- With `ready_i` low, `result_o`, `zero_o` and `illegal_o` stay stable.
- `flush_i` has priority over everything:
  - Next edge: state IDLE, `valid_o` 0. Result registers keep their stale values.
  - `flush_i` together with `valid_i` in IDLE: the op is dropped.
- Asynchronous reset mid-BUSY or mid-DONE: immediate return to reset values; the op is lost.

## Structure
- `alu_pkg`: op-code localparams (5-bit), the `is_muldiv`/`is_signed_*` decode functions, and the state enum (IDLE/BUSY/DONE).
- Sub-module `muldiv_iter`: shared multiply/divide datapath. It holds the 2·XLEN accumulator, the iteration counter and the sign-fix logic, with start/done strobes. The top level holds the FSM, base-op logic, special-case detection and output registers.

## Test plan
- Reset release, then ADD 5+7 with `ready_i`=1 → `valid_o` at t+1, `result_o`=12, `zero_o`=0; SUB 7−7 → 0, `zero_o`=1.
- SRA 0x8000_0000 by 0x21 (shift 1) → 0xC000_0000. SLT −1<1 → 1; SLTU 0xFFFF_FFFF<1 → 0.
- MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000 at t+34. MUL 0xFFFF_FFFF × 3 → 0xFFFF_FFFD. MULHSU −1 × 0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV −7/2 → −3, REM −7/2 → −1 (t+34). DIVU 5/0 → 0xFFFF_FFFF at t+1. DIV 0x8000_0000/−1 → 0x8000_0000 and REM → 0, both at t+1.
- Hold `ready_i`=0 for 10 cycles after DONE → outputs stable, `ready_o`=0. Release → accept on that edge, `ready_o`=1 the next cycle.
- `flush_i` at cycle 10 of a DIV → `valid_o` never rises, `ready_o`=1 next cycle. Op 12 → `illegal_o`=1, `result_o`=0 at t+1. Async reset in BUSY → all outputs reset immediately.
